// File: rtl/pingpong_writer.sv
// pingpong_writer
//   Producer-side controller for the two-bank (ram1/ram2) display double
//   buffer. It takes a valid/ready sample stream and fills one 32-entry bank
//   while the display reader drains the other. Banks are filled and read
//   alternately, starting with ram1.
//
// Optional feature (macro PINGPONG_STALL_CNT_EN):
//   Adds output stall_cnt[15:0]. It counts the edges where in_valid = 1 and
//   in_ready = 0, saturates at 16'hFFFF, and is cleared only by resetn.
//
// Ports
//   clk_new            clock
//   resetn             synchronous, active-low reset
//   in_valid/in_data   sample stream from the producer
//   in_ready           block accepts a sample this cycle (state decode only)
//   rd_done            one-cycle pulse: reader has finished bank rd_bank
//   ram1_write_*       bank 1 write port (registered)
//   ram2_write_*       bank 2 write port (registered)
//   bank_full          bit0 = ram1 holds a frame, bit1 = ram2 holds a frame
//   rd_bank            bank the reader must consume next (0 = ram1, 1 = ram2)
//   frame_ready        one-cycle pulse when a bank becomes full
module pingpong_writer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk_new,
    input  logic              resetn,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              rd_done,
    output logic              ram1_write_en,
    output logic [ADDR_W-1:0] ram1_write_address,
    output logic [DATA_W-1:0] ram1_write_data,
    output logic              ram2_write_en,
    output logic [ADDR_W-1:0] ram2_write_address,
    output logic [DATA_W-1:0] ram2_write_data,
    output logic [1:0]        bank_full,
`ifdef PINGPONG_STALL_CNT_EN
    output logic [15:0]       stall_cnt,
`endif
    output logic              rd_bank,
    output logic              frame_ready
);

    typedef enum logic {FILL = 1'b0, WAIT = 1'b1} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic              wr_bank;
    logic [ADDR_W-1:0] wr_ptr;
    // A completed bank is flagged full one edge after its last transfer, so
    // the reader never sees it before the final word is committed.
    logic              set_pend;
    logic              set_bank;

    logic       xfer;
    logic       last;
    logic       clr;
    logic [1:0] bf_nxt;

    assign in_ready = (state == FILL);
    assign xfer     = in_valid && in_ready;
    assign last     = xfer && (wr_ptr == LAST_ADDR);
    assign clr      = rd_done && bank_full[rd_bank];

    // Occupancy after this edge: the reader's clear and the delayed set
    // always target different banks, so both apply.
    always_comb begin
        bf_nxt = bank_full;
        if (clr)
            bf_nxt[rd_bank] = 1'b0;
        if (set_pend)
            bf_nxt[set_bank] = 1'b1;
    end

    always_ff @(posedge clk_new) begin
        if (!resetn) begin
            state              <= FILL;
            wr_bank            <= 1'b0;
            wr_ptr             <= '0;
            bank_full          <= 2'b00;
            rd_bank            <= 1'b0;
            frame_ready        <= 1'b0;
            set_pend           <= 1'b0;
            set_bank           <= 1'b0;
            ram1_write_en      <= 1'b0;
            ram1_write_address <= '0;
            ram1_write_data    <= '0;
            ram2_write_en      <= 1'b0;
            ram2_write_address <= '0;
            ram2_write_data    <= '0;
        end else begin
            // Write port: one registered strobe per accepted sample.
            ram1_write_en <= xfer && !wr_bank;
            ram2_write_en <= xfer &&  wr_bank;
            if (xfer && !wr_bank) begin
                ram1_write_address <= wr_ptr;
                ram1_write_data    <= in_data;
            end
            if (xfer && wr_bank) begin
                ram2_write_address <= wr_ptr;
                ram2_write_data    <= in_data;
            end

            if (xfer)
                wr_ptr <= last ? '0 : wr_ptr + 1'b1;

            set_pend    <= last;
            set_bank    <= wr_bank;
            frame_ready <= set_pend;
            bank_full   <= bf_nxt;
            if (clr)
                rd_bank <= ~rd_bank;

            case (state)
                FILL: begin
                    if (last) begin
                        wr_bank <= ~wr_bank;
                        // Park if the bank we move to still holds an unread
                        // frame once this edge's clear/set have applied.
                        if (bf_nxt[~wr_bank])
                            state <= WAIT;
                    end
                end
                WAIT: begin
                    if (!bank_full[wr_bank])
                        state <= FILL;
                end
                default: state <= FILL;
            endcase
        end
    end

`ifdef PINGPONG_STALL_CNT_EN
    always_ff @(posedge clk_new) begin
        if (!resetn)
            stall_cnt <= '0;
        else if (in_valid && !in_ready && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

    // The writer only fills an empty bank and the reader only clears a full
    // one, so a set and a clear never land on the same bank.
    always_ff @(posedge clk_new) begin
        if (resetn)
            assert (!(set_pend && clr && (set_bank == rd_bank)));
    end

endmodule

// File: tb/tb_pingpong_writer.sv
module tb_pingpong_writer;

    logic       clk_new = 1'b0;
    logic       resetn;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       rd_done;
    logic       ram1_write_en;
    logic [4:0] ram1_write_address;
    logic [7:0] ram1_write_data;
    logic       ram2_write_en;
    logic [4:0] ram2_write_address;
    logic [7:0] ram2_write_data;
    logic [1:0] bank_full;
    logic       rd_bank;
    logic       frame_ready;
`ifdef PINGPONG_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_new = ~clk_new;

    pingpong_writer #(.DATA_W(8), .ADDR_W(5), .DEPTH(32)) dut (
        .clk_new            (clk_new),
        .resetn             (resetn),
        .in_valid           (in_valid),
        .in_data            (in_data),
        .in_ready           (in_ready),
        .rd_done            (rd_done),
        .ram1_write_en      (ram1_write_en),
        .ram1_write_address (ram1_write_address),
        .ram1_write_data    (ram1_write_data),
        .ram2_write_en      (ram2_write_en),
        .ram2_write_address (ram2_write_address),
        .ram2_write_data    (ram2_write_data),
        .bank_full          (bank_full),
`ifdef PINGPONG_STALL_CNT_EN
        .stall_cnt          (stall_cnt),
`endif
        .rd_bank            (rd_bank),
        .frame_ready        (frame_ready)
    );

    task automatic tick();
        @(posedge clk_new);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // n back-to-back transfers into 'bank', checking each registered strobe.
    task automatic fill(input int n, input logic bank, input int addr0, input logic [7:0] base);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_data  = base + 8'(k);
            tick();
            if (!bank) begin
                chk("w1_en",   {31'd0, ram1_write_en}, 32'd1);
                chk("w1_addr", {27'd0, ram1_write_address}, 32'(addr0 + k));
                chk("w1_data", {24'd0, ram1_write_data}, {24'd0, base + 8'(k)});
                chk("w2_idle", {31'd0, ram2_write_en}, 32'd0);
            end else begin
                chk("w2_en",   {31'd0, ram2_write_en}, 32'd1);
                chk("w2_addr", {27'd0, ram2_write_address}, 32'(addr0 + k));
                chk("w2_data", {24'd0, ram2_write_data}, {24'd0, base + 8'(k)});
                chk("w1_idle", {31'd0, ram1_write_en}, 32'd0);
            end
        end
    endtask

    initial begin
        resetn = 1'b0; in_valid = 1'b0; in_data = 8'h00; rd_done = 1'b0;
        tick(); tick();
        resetn = 1'b1;
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_full",  {30'd0, bank_full}, 32'd0);
        chk("rst_rdb",   {31'd0, rd_bank}, 32'd0);
        chk("rst_fr",    {31'd0, frame_ready}, 32'd0);
        chk("rst_en",    {30'd0, ram1_write_en, ram2_write_en}, 32'd0);

        // ram1: 32 samples 00..1F
        fill(32, 1'b0, 0, 8'h00);
        in_valid = 1'b0;
        chk("r1_notfull_yet", {30'd0, bank_full}, 32'd0);
        chk("r1_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("r1_full", {30'd0, bank_full}, 32'd1);
        chk("r1_fr",   {31'd0, frame_ready}, 32'd1);
        chk("r1_en0",  {31'd0, ram1_write_en}, 32'd0);
        tick();
        chk("r1_fr_1cyc", {31'd0, frame_ready}, 32'd0);

        // ram2: 32 samples 80..9F, then both banks full
        fill(32, 1'b1, 0, 8'h80);
        in_valid = 1'b0;
        chk("wait_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("both_full", {30'd0, bank_full}, 32'd3);
        chk("r2_fr",     {31'd0, frame_ready}, 32'd1);

        // stall: in_valid held 10 cycles, no strobes
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1; in_data = 8'hEE;
            tick();
            chk("stall_en", {30'd0, ram1_write_en, ram2_write_en}, 32'd0);
            chk("stall_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        chk("stall_full", {30'd0, bank_full}, 32'd3);
`ifdef PINGPONG_STALL_CNT_EN
        chk("stall_cnt", {16'd0, stall_cnt}, 32'd10);
`endif

        // reader hands back ram1
        rd_done = 1'b1; tick(); rd_done = 1'b0;
        chk("rd1_full", {30'd0, bank_full}, 32'd2);
        chk("rd1_rdb",  {31'd0, rd_bank}, 32'd1);
        chk("rd1_ready_lo", {31'd0, in_ready}, 32'd0);
        tick();
        chk("rd1_ready_hi", {31'd0, in_ready}, 32'd1);
        fill(1, 1'b0, 0, 8'hA5);
        in_valid = 1'b0;

        // reader hands back ram2, then a spurious rd_done is ignored
        rd_done = 1'b1; tick();
        chk("rd2_full", {30'd0, bank_full}, 32'd0);
        chk("rd2_rdb",  {31'd0, rd_bank}, 32'd0);
        tick(); rd_done = 1'b0;
        chk("spur_full", {30'd0, bank_full}, 32'd0);
        chk("spur_rdb",  {31'd0, rd_bank}, 32'd0);

        // finish ram1, 17 into ram2, then reset mid-fill
        fill(31, 1'b0, 1, 8'h40);
        fill(17, 1'b1, 0, 8'hC0);
        resetn = 1'b0;
        tick();
        chk("mrst_en",    {30'd0, ram1_write_en, ram2_write_en}, 32'd0);
        chk("mrst_full",  {30'd0, bank_full}, 32'd0);
        chk("mrst_rdb",   {31'd0, rd_bank}, 32'd0);
        chk("mrst_fr",    {31'd0, frame_ready}, 32'd0);
        chk("mrst_addr",  {27'd0, ram2_write_address}, 32'd0);
        chk("mrst_data",  {24'd0, ram2_write_data}, 32'd0);
        chk("mrst_ready", {31'd0, in_ready}, 32'd1);
`ifdef PINGPONG_STALL_CNT_EN
        chk("mrst_stall", {16'd0, stall_cnt}, 32'd0);
`endif
        resetn = 1'b1;
        fill(1, 1'b0, 0, 8'h3C);

        // same-edge: last word of ram2 with rd_done for ram1
        fill(31, 1'b0, 1, 8'h10);
        in_valid = 1'b0;
        tick();
        chk("se_pre_full", {30'd0, bank_full}, 32'd1);
        fill(31, 1'b1, 0, 8'h60);
        rd_done = 1'b1;
        fill(1, 1'b1, 31, 8'h7F);
        rd_done = 1'b0; in_valid = 1'b0;
        chk("se_rdb",   {31'd0, rd_bank}, 32'd1);
        chk("se_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("se_full",  {30'd0, bank_full}, 32'd2);
        chk("se_fr",    {31'd0, frame_ready}, 32'd1);
        chk("se_ready2", {31'd0, in_ready}, 32'd1);
        fill(1, 1'b0, 0, 8'h5A);
        in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pingpong_writer.md
Name: pingpong_writer

Overview:
- Producer-side controller for the two-bank (ram1/ram2) display double buffer.
- Accepts a valid/ready sample stream, e.g. from data_generation, and fills one 32-entry bank while the display reader drains the other.
- Publishes per-bank full flags and the bank the reader must consume next; the reader hands a bank back with a one-cycle done pulse.

Parameters:
DATA_W, 8, width of each sample and each RAM word
ADDR_W, 5, RAM address width
DEPTH, 32, words per bank; must be <= 2**ADDR_W

Ports:
clk_new  input  1  block clock
resetn  input  1  synchronous, active-low reset
in_valid  input  1  sample available
in_data  input  DATA_W  sample value
in_ready  output  1  block can accept a sample this cycle
rd_done  input  1  one-cycle pulse: reader has finished bank rd_bank
ram1_write_en  output  1  bank 1 write strobe
ram1_write_address  output  ADDR_W  bank 1 write address
ram1_write_data  output  DATA_W  bank 1 write data
ram2_write_en  output  1  bank 2 write strobe
ram2_write_address  output  ADDR_W  bank 2 write address
ram2_write_data  output  DATA_W  bank 2 write data
bank_full  output  2  bit0 = ram1 holds a complete frame; bit1 = ram2 holds a complete frame
rd_bank  output  1  bank the reader must read next (0 = ram1, 1 = ram2)
frame_ready  output  1  one-cycle pulse when a bank becomes full

Behaviour:
- Reset: clk_new is the clock; resetn is synchronous, active-low.
  - While resetn = 0 at a clock edge: state <= FILL, wr_bank <= 0, wr_ptr <= 0, bank_full <= 2'b00, rd_bank <= 0, frame_ready <= 0.
  - Also at reset: all write_en <= 0, all write_address/data <= 0.
  - Reset mid-fill discards the partial bank; no write strobe is issued in the cycle after reset.
- Handshake:
  - Transfer occurs on an edge where in_valid && in_ready.
  - in_ready = (state == FILL), decoded from registers only, with no combinational path from in_valid.
  - in_data is held by the source until the transfer completes.
- Write path latency:
  - A transfer at edge E registers the write for bank wr_bank: ramX_write_en = 1, address = wr_ptr, data = in_data, all valid during the cycle after E.
  - The RAM commits the word at edge E+1.
  - The non-selected bank's write_en stays 0.
  - write_en is 0 in any cycle not following a transfer.
- Pointer:
  - wr_ptr increments on each transfer.
  - On the transfer with wr_ptr == DEPTH-1, wr_ptr wraps to 0 and the bank completes.
- Bank completion (transfer at edge E is the last word):
  - At edge E+1: bank_full[wr_bank] <= 1 and frame_ready pulses for exactly one cycle.
  - The reader never sees full before the last word is committed.
  - At edge E: wr_bank toggles.
  - If the other bank is already full, or becomes full at E+1, state <= WAIT; otherwise state stays FILL.
  - in_ready is high in the cycle immediately after E only when the other bank is empty.
- States:
  - FILL: accept samples.
  - WAIT: in_ready = 0 until bank_full[wr_bank] clears, then FILL on the next edge.
- Reader side:
  - On rd_done with bank_full[rd_bank] = 1: clear bank_full[rd_bank] and toggle rd_bank.
  - rd_done with bank_full[rd_bank] = 0 is ignored; no state change.
- Simultaneous events:
  - Set of one bank and clear of the other on the same edge both take effect.
  - A set and clear targeting the same bank on the same edge cannot occur by construction; the verifier asserts this.
- Ordering: banks are always filled and read alternately starting with ram1; rd_bank always names the oldest full bank.
- Stall: when both banks are full the writer holds in WAIT indefinitely; no data is dropped or overwritten.

Optional Feature:
- Macro PINGPONG_STALL_CNT_EN.
- When defined: adds output stall_cnt [15:0].
  - Increments on every edge where in_valid = 1 and in_ready = 0.
  - Saturates at 16'hFFFF; reset to 0.
  - Cleared by resetn only.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then 32 back-to-back transfers of 8'h00..8'h1F:
  - ram1 strobes addr 0..31 with data 0..31.
  - bank_full = 01 and frame_ready pulses one cycle after the last strobe.
  - in_ready stays high; the next transfer writes ram2 addr 0.
- Fill both banks (64 transfers, no rd_done):
  - bank_full = 11, in_ready = 0, state WAIT.
  - Holding in_valid = 1 for 10 cycles produces no strobes; stall_cnt = 10 when the macro is enabled.
- From both banks full, pulse rd_done:
  - bank_full = 10, rd_bank = 1.
  - in_ready rises on the following edge; the next sample writes ram1 addr 0.
- rd_done pulsed with bank_full = 00: no change to bank_full or rd_bank.
- Assert resetn = 0 after 17 transfers into ram2 (ram1 full):
  - All outputs return to reset values; the next transfer writes ram1 addr 0.
- Same-edge event: last word of ram2 completes on the same edge the reader pulses rd_done for ram1.
  - bank_full goes from 01 to 10.
  - rd_bank goes to 1.
  - Writer stays in FILL on ram1.
